// File: rtl/prog_memory_loader.sv
// prog_memory_loader: program memory for the fetch stage with a byte-stream loader.
// Fetch reads happen on the falling clock edge. Loader writes happen on the rising edge.
// The loader packs bytes, most significant byte first, into words.
// It writes each completed word at the next sequential address.
// A load ends when the memory is full. If PROG_MEM_HALT_DETECT_EN is defined, a load
// also ends when the completed word equals HALT_WORD.
module prog_memory_loader #(
    parameter int                     NB_DATA_BUS = 32,
    parameter int                     N_ADDRESS   = 64,
    parameter int                     NB_ADDRESS  = $clog2(N_ADDRESS),
    parameter int                     NB_BYTE     = 8,
    parameter logic [NB_DATA_BUS-1:0] HALT_WORD   = 32'hFFFF_FFFF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NB_ADDRESS-1:0] i_r_addr,
    input  logic                  i_r_en,
    output logic [NB_DATA_BUS-1:0] o_r_data,
    input  logic                  i_load_start,
    input  logic [NB_BYTE-1:0]    i_load_byte,
    input  logic                  i_load_valid,
    output logic                  o_load_ready,
    output logic                  o_loaded,
    output logic                  o_busy,
    output logic [NB_ADDRESS:0]   o_word_count
);

    localparam int                    BPW       = NB_DATA_BUS / NB_BYTE;
    localparam int                    NB_BCNT   = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [NB_BCNT-1:0]    LAST_BYTE = NB_BCNT'(BPW - 1);
    localparam logic [NB_ADDRESS:0]   DEPTH     = (NB_ADDRESS + 1)'(N_ADDRESS);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                  state_q, state_d;
    logic [NB_BCNT-1:0]      bcnt_q, bcnt_d;
    logic [NB_ADDRESS-1:0]   waddr_q, waddr_d;
    logic [NB_ADDRESS:0]     wcnt_q, wcnt_d;
    logic [NB_DATA_BUS-1:0]  asm_q, asm_d;
    logic                    halt_q, halt_d;
    logic [NB_DATA_BUS-1:0]  r_data_q;

    logic [NB_DATA_BUS-1:0]  mem [N_ADDRESS];

    logic [NB_DATA_BUS+NB_BYTE-1:0] asm_shift;
    logic [NB_DATA_BUS-1:0]  wr_word;
    logic                    wr_en;
    logic                    clear;
    logic                    load_end;
    logic                    halt_en;

`ifdef PROG_MEM_HALT_DETECT_EN
    assign halt_en = 1'b1;
`else
    assign halt_en = 1'b0;
`endif

    // Shifting through a wider vector also covers the case of one byte per word.
    assign asm_shift = {asm_q, i_load_byte};
    assign wr_word   = asm_shift[NB_DATA_BUS-1:0];

    // The load ends one edge after the last write (memory full or halt word).
    // Until then, no further bytes are accepted.
    assign load_end  = (wcnt_q == DEPTH) || halt_q;

    assign o_r_data     = r_data_q;
    assign o_word_count = wcnt_q;

    // Next-state logic, loader datapath and status outputs.
    always_comb begin
        state_d      = state_q;
        bcnt_d       = bcnt_q;
        waddr_d      = waddr_q;
        wcnt_d       = wcnt_q;
        asm_d        = asm_q;
        halt_d       = halt_q;
        wr_en        = 1'b0;
        clear        = 1'b0;
        o_load_ready = 1'b0;
        o_busy       = 1'b0;
        o_loaded     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_load_start) begin
                    state_d = LOAD;
                    clear   = 1'b1;
                end
            end
            LOAD: begin
                o_busy       = 1'b1;
                o_load_ready = !load_end;
                if (i_load_start) begin
                    // A restart wins over a byte offered in the same cycle.
                    clear = 1'b1;
                end else if (load_end) begin
                    state_d = DONE;
                end else if (i_load_valid) begin
                    asm_d = wr_word;
                    if (bcnt_q == LAST_BYTE) begin
                        bcnt_d  = '0;
                        wr_en   = 1'b1;
                        waddr_d = waddr_q + 1'b1;
                        wcnt_d  = wcnt_q + 1'b1;
                        halt_d  = halt_en && (wr_word == HALT_WORD);
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                o_loaded = 1'b1;
                if (i_load_start) begin
                    state_d = LOAD;
                    clear   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear) begin
            bcnt_d  = '0;
            waddr_d = '0;
            wcnt_d  = '0;
            halt_d  = 1'b0;
            asm_d   = '0;
        end
    end

    // FSM and loader counters; an asynchronous reset returns the loader to IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            waddr_q <= '0;
            wcnt_q  <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            waddr_q <= waddr_d;
            wcnt_q  <= wcnt_d;
            halt_q  <= halt_d;
        end
    end

    // The assembly register is pure data. A cleared byte counter invalidates it.
    always_ff @(posedge i_clk) begin
        asm_q <= asm_d;
    end

    // Word write on the edge that accepts the last byte. Contents survive reset.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[waddr_q] <= wr_word;
        end
    end

    // Fetch port: falling-edge registered read, holds when not enabled.
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data_q <= '0;
        end else if (i_r_en) begin
            r_data_q <= mem[i_r_addr];
        end
    end

endmodule

// File: doc/prog_memory_loader.md
# prog_memory_loader

Parametrised program memory for the pipeline's fetch stage with a built-in byte-stream loader. The fetch port keeps the synchronous falling-edge read behaviour, gated by an enable, that the stage already relies on. A handshaked byte interface, driven by the debug/UART unit, assembles bytes into words and writes them at sequential addresses. This lets a program be downloaded at run time instead of being fixed at synthesis.

## Interface
- NB_DATA_BUS, 32, word width; must be an integer multiple of NB_BYTE
- N_ADDRESS, 64, memory depth in words
- NB_ADDRESS, $clog2(N_ADDRESS), address width
- NB_BYTE, 8, width of one load byte
- HALT_WORD, 32'hFFFF_FFFF, word value that ends a load early (used only with the macro)

Ports:
- i_clk  in  1  clock. Writes and state change on the rising edge; fetch reads on the falling edge.
- i_rst_n  in  1  asynchronous, active-low reset
- i_r_addr  in  NB_ADDRESS  fetch word address
- i_r_en  in  1  fetch read enable
- o_r_data  out  NB_DATA_BUS  registered fetch data
- i_load_start  in  1  one-cycle pulse that starts or restarts a load
- i_load_byte  in  NB_BYTE  load byte, most significant byte of each word first
- i_load_valid  in  1  i_load_byte is valid
- o_load_ready  out  1  loader accepts a byte this cycle
- o_loaded  out  1  load completed
- o_busy  out  1  load in progress
- o_word_count  out  NB_ADDRESS+1  number of words written in the current or last load

## Operation
- BPW = NB_DATA_BUS/NB_BYTE bytes per word. Internal state:
  - byte counter, 0..BPW-1
  - write address, NB_ADDRESS bits
  - word counter, NB_ADDRESS+1 bits
  - assembly shift register, NB_DATA_BUS bits
- FSM states IDLE, LOAD, DONE. Reset state is IDLE.
- IDLE
  - o_load_ready=0, o_busy=0, o_loaded=0.
  - i_load_start moves to LOAD and clears the byte counter, write address and word counter.
- LOAD
  - o_load_ready=1, o_busy=1.
  - A byte is accepted when i_load_valid=1 and o_load_ready=1. On acceptance: assembly register <= {assembly[NB_DATA_BUS-NB_BYTE-1:0], i_load_byte}, and the byte counter increments.
  - On the BPW-th accepted byte: the completed word is written to mem[write address] on that same edge, the write address and word counter increment, and the byte counter wraps to 0.
  - After that write, if the word counter equals N_ADDRESS, the FSM moves to DONE. Bytes presented after this are not accepted.
  - i_load_start while in LOAD aborts the load: it discards the partial word, clears all counters and stays in LOAD. Words already written remain in memory.
  - If i_load_start and a byte acceptance occur in the same cycle, the restart wins and the byte is dropped.
- DONE
  - o_loaded=1, o_load_ready=0, o_busy=0.
  - o_word_count holds its value.
  - i_load_start moves to LOAD with counters cleared.
- Fetch read
  - On the falling edge of i_clk, if i_r_en=1, o_r_data <= mem[i_r_addr]. Otherwise o_r_data holds.
  - Reads are legal in every state. During LOAD they return the current memory contents.
- Memory contents are never cleared by reset.

## Timing
- Reset values: o_r_data=0, o_load_ready=0, o_loaded=0, o_busy=0, o_word_count=0, FSM=IDLE. Reset acts immediately on assertion.
- Reset asserted mid-load returns the block to IDLE. Words already written are retained and the partial word is lost.
- Load byte acceptance rate: 1 byte per cycle maximum. A word is written on the rising edge that accepts its last byte.
- Fetch read latency: o_r_data is valid half a cycle after the rising edge at which i_r_addr and i_r_en were presented, i.e. at the following falling edge.
- Write then read of the same address: a write on rising edge k is visible to a read at the falling edge of cycle k.
- o_word_count updates on the write edge. o_loaded rises on the rising edge after the final write.

## Configuration
- PROG_MEM_HALT_DETECT_EN
  - Defined: when a completed word equals HALT_WORD, the word is still written and counted, and the FSM moves to DONE on the same edge as a depth-full end. Remaining space is left untouched.
  - Undefined: HALT_WORD has no effect, and a load ends only when N_ADDRESS words have been written.

## Test plan
- Reset check: assert i_rst_n=0 mid-cycle -> all outputs 0 immediately and FSM is IDLE. Release, then read address 0 -> returns the prior memory contents, unaffected by reset.
- Basic load: pulse start, then stream bytes 12,34,56,78,9A,BC,DE,F0 with valid held high -> mem[0]=32'h12345678, mem[1]=32'h9ABCDEF0, o_word_count=2. A fetch of address 1 returns 32'h9ABCDEF0.
- Depth-full load: stream 4*64 bytes with valid toggling -> o_loaded=1 one cycle after the 64th write. Extra bytes are not accepted (o_load_ready=0) and o_word_count=64.
- Restart: send 6 bytes, then pulse start together with a valid byte -> that byte is dropped and the counters clear. The next 4 bytes AA,BB,CC,DD write mem[0]=32'hAABBCCDD; mem[1] is unchanged.
- Halt, with the macro defined: send word 0x00000001, then 0xFFFFFFFF -> DONE with o_word_count=2. The same stimulus without the macro stays in LOAD with o_word_count=2.
- Same-address write/read: the final byte of word 3 is accepted at rising edge k while i_r_addr=3 and i_r_en=1 -> o_r_data after falling edge k equals the new word.
